// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline register stage (main + skid) with registered ready,
// synchronous flush that kills held and incoming entries, and a saturating
// stall-cycle counter.
//
// Handshake: an entry moves on an edge where valid and ready are both 1 on
// that side. in_ready is a register (1 whenever the stage is not full) and
// out_valid/out_ctrl/out_data come straight from the main register, so no
// combinational path runs from any input to any output.
module pipe_stage_skid #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 111,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q;
  logic                in_ready_q;
  logic                main_valid_q;
  logic [CTRL_W-1:0]   main_ctrl_q;
  logic [DATA_W-1:0]   main_data_q;
  logic [CTRL_W-1:0]   skid_ctrl_q;
  logic [DATA_W-1:0]   skid_data_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    stall_cnt_d;

  logic xfer_in;
  logic xfer_out;
  logic stall_hit;

  assign xfer_in   = in_valid & in_ready_q;
  assign xfer_out  = main_valid_q & out_ready;
  assign stall_hit = main_valid_q & ~out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  // Storage FSM: rst beats flush beats the normal handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else if (flush) begin
      // Drop everything; payloads are left as they were.
      state_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (xfer_in) begin
            main_ctrl_q  <= in_ctrl;
            main_data_q  <= in_data;
            main_valid_q <= 1'b1;
            state_q      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (xfer_in && !xfer_out) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
            state_q     <= ST_TWO;
            in_ready_q  <= 1'b0;
          end else if (xfer_in && xfer_out) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (xfer_out) begin
            main_valid_q <= 1'b0;
            state_q      <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (xfer_out) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            state_q     <= ST_ONE;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_EMPTY;
          in_ready_q   <= 1'b1;
          main_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles where the head is valid but not taken.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_hit && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register; only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios followed by a long random
// handshake run, all checked against a two-deep queue reference model.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 9;
  localparam int DATA_W = 111;
  localparam int CNT_W  = 16;
  localparam int E_W    = CTRL_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  // Small-counter instance used only for the saturation scenario.
  logic              sat_in_valid = 1'b0;
  logic              sat_in_ready;
  logic              sat_out_valid;
  logic              sat_out_ready = 1'b1;
  logic [CTRL_W-1:0] sat_out_ctrl;
  logic [DATA_W-1:0] sat_out_data;
  logic [1:0]        sat_occupancy;
  logic [2:0]        sat_stall_cnt;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .in_ctrl(9'h1A5), .in_data({DATA_W{1'b1}}),
    .out_valid(sat_out_valid), .out_ready(sat_out_ready),
    .out_ctrl(sat_out_ctrl), .out_data(sat_out_data),
    .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [E_W-1:0]   exp_q[$];
  logic [CNT_W-1:0] exp_stall = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference: a queue of at most two entries. Ready means "fewer than two
  // held at the start of the cycle"; the head leaves when out_ready is 1.
  task automatic model_edge(input logic v, input logic [CTRL_W-1:0] c,
                            input logic [DATA_W-1:0] d, input logic ordy,
                            input logic fl, input logic r);
    int  sz;
    logic do_out, do_in;
    sz = exp_q.size();
    if (r) begin
      exp_q.delete();
      exp_stall = '0;
      return;
    end
    if (sz > 0 && !ordy && exp_stall != {CNT_W{1'b1}}) exp_stall = exp_stall + 1'b1;
    if (fl) begin
      exp_q.delete();
      return;
    end
    do_out = (sz > 0) && ordy;
    do_in  = v && (sz < 2);
    if (do_out) void'(exp_q.pop_front());
    if (do_in) exp_q.push_back({c, d});
  endtask

  task automatic compare_all();
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("in_ready", in_ready, exp_q.size() < 2);
    chk("occupancy", occupancy, exp_q.size());
    chk("stall_cnt", stall_cnt, exp_stall);
    if (exp_q.size() > 0) begin
      chk("out_ctrl", out_ctrl, exp_q[0][E_W-1:DATA_W]);
      chk("out_data", out_data, exp_q[0][DATA_W-1:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [CTRL_W-1:0] c,
                      input logic [DATA_W-1:0] d, input logic ordy,
                      input logic fl, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
    model_edge(v, c, d, ordy, fl, r);
    compare_all();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input logic ordy);
    step(1'b1, c, d, ordy, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_ctrl"}, out_ctrl, '0);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_ready"}, in_ready, 1'b1);
    chk({tag, "_occ"}, occupancy, 2'd0);
    chk({tag, "_stall"}, stall_cnt, '0);
  endtask

  logic [127:0] rnd;

  initial begin
    // Reset.
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    check_reset_values("reset");

    // Saturation on the 3-bit counter instance; main DUT stays idle and empty.
    @(negedge clk);
    rst = 1'b0;
    sat_in_valid  = 1'b1;
    sat_out_ready = 1'b0;
    @(negedge clk);
    sat_in_valid = 1'b0;
    chk("sat_start", sat_stall_cnt, 3'd0);
    repeat (10) @(negedge clk);
    chk("sat_10", sat_stall_cnt, 3'd7);
    repeat (3) @(negedge clk);
    chk("sat_hold", sat_stall_cnt, 3'd7);
    chk("sat_occ", sat_occupancy, 2'd1);
    sat_out_ready = 1'b1;

    // Streaming 1..4 with both sides always ready.
    for (int i = 1; i <= 4; i++) begin
      push(9'(i), DATA_W'(i), 1'b1);
      chk("stream_data", out_data, DATA_W'(i));
      chk("stream_occ", occupancy, 2'd1);
    end
    idle(1'b1);
    chk("stream_stall", stall_cnt, '0);

    // Backpressure: A, B held; a third offer is refused while full.
    push(9'h0A, DATA_W'(128'hA), 1'b0);
    push(9'h0B, DATA_W'(128'hB), 1'b0);
    chk("bp_occ2", occupancy, 2'd2);
    chk("bp_ready0", in_ready, 1'b0);
    chk("bp_stall1", stall_cnt, 16'd1);
    push(9'h0D, DATA_W'(128'hD), 1'b0);
    chk("bp_stall2", stall_cnt, 16'd2);
    idle(1'b1);
    chk("bp_head_b", out_data, DATA_W'(128'hB));
    chk("bp_ready1", in_ready, 1'b1);
    idle(1'b1);
    chk("bp_empty", out_valid, 1'b0);

    // Flush while full, with C offered in the same cycle.
    push(9'h1F1, DATA_W'(128'h51), 1'b0);
    push(9'h1F2, DATA_W'(128'h52), 1'b0);
    chk("fl_occ2", occupancy, 2'd2);
    step(1'b1, 9'h0C, DATA_W'(128'hC), 1'b0, 1'b1, 1'b0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ctrl", out_ctrl, '0);
    chk("fl_occ", occupancy, 2'd0);
    chk("fl_ready", in_ready, 1'b1);
    chk("fl_stall", stall_cnt, 16'd4);
    repeat (3) idle(1'b1);

    // Reset mid-stream with one entry held and five stalled cycles.
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    push(9'h0E, DATA_W'(128'hE), 1'b0);
    repeat (5) idle(1'b0);
    chk("mid_occ", occupancy, 2'd1);
    chk("mid_stall", stall_cnt, 16'd5);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_reset_values("mid_reset");
    push(9'h0F, DATA_W'(128'hF), 1'b1);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_data", out_data, DATA_W'(128'hF));

    // Random handshake run.
    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 1) == 1, rnd[127:127-CTRL_W+1], rnd[DATA_W-1:0],
           $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0,
           $urandom_range(0, 499) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Parameters
REQ-001 The block SHALL expose parameter CTRL_W, default 9, meaning the width of the control field (RegDst, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUsrc, RegWrite plus one spare bit); it is zeroed on flush.
REQ-002 The block SHALL expose parameter DATA_W, default 111, meaning the width of the payload field (rs, rt, rd, immediate, read1, read2); it is never zeroed by flush.
REQ-003 The block SHALL expose parameter CNT_W, default 16, meaning the width of the stall-cycle counter.

Interface
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous kill of all held and incoming entries.
REQ-007 in_valid  in  1  upstream presents an entry.
REQ-008 in_ready  out  1  block can accept an entry this cycle.
REQ-009 in_ctrl  in  CTRL_W  upstream control field.
REQ-010 in_data  in  DATA_W  upstream payload field.
REQ-011 out_valid  out  1  head entry valid.
REQ-012 out_ready  in  1  downstream consumes the head entry.
REQ-013 out_ctrl  out  CTRL_W  head control field.
REQ-014 out_data  out  DATA_W  head payload field.
REQ-015 occupancy  out  2  number of held entries (0..2).
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Storage SHALL be two entries, a main register and a skid register, with states EMPTY (occupancy 0), ONE (occupancy 1, main valid) and TWO (occupancy 2, main and skid valid).
REQ-018 A transfer in SHALL occur when in_valid and in_ready are both 1; a transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-019 in_ready SHALL be a registered output, equal to 1 exactly when the state is not TWO; it SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid, out_ctrl and out_data SHALL be driven directly from the main register, with no combinational path from any input.
REQ-021 Latency SHALL be one cycle: an entry accepted in EMPTY at edge N appears on the outputs after edge N.
REQ-022 State transitions, for state EMPTY:
- transfer in moves to ONE;
- otherwise the block stays in EMPTY.
REQ-023 State transitions, for state ONE:
- transfer in without transfer out moves to TWO, with the new entry written to the skid register;
- transfer in with transfer out stays in ONE, with the new entry written to the main register;
- transfer out alone moves to EMPTY;
- otherwise the block stays in ONE.
REQ-024 State transitions, for state TWO:
- transfer out moves to ONE, with the skid entry moved to the main register;
- otherwise the block stays in TWO;
- no transfer in is possible in TWO.
REQ-025 Order SHALL be preserved: entries leave strictly in acceptance order, with no loss and no duplication.
REQ-026 flush (with rst=0) SHALL force the state to EMPTY and clear both entries' valid bits and control fields to 0, regardless of in_valid or out_ready.
REQ-027 During flush, payload fields SHALL hold their previous values.
REQ-028 An entry presented in the same cycle as flush SHALL be discarded.
REQ-029 in_ready SHALL be 1 in the cycle after a flush.
REQ-030 Priority SHALL be rst > flush > normal handshake.
REQ-031 stall_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=0.
REQ-032 stall_cnt SHALL saturate at 2^CNT_W-1.
REQ-033 stall_cnt SHALL be unaffected by flush.
REQ-034 occupancy SHALL track the state exactly after every edge.

Reset
REQ-035 When rst=1 at a rising edge, the block SHALL set: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid register=0, in_ready=1, occupancy=0, stall_cnt=0.
REQ-036 A reset asserted mid-operation (state ONE or TWO) SHALL discard all entries in the same edge, with no partial transfer.
REQ-037 After rst deasserts, the block SHALL accept an entry on the first edge.

Verification
REQ-038 Streaming: in_valid=1 and out_ready=1 continuously, data 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles, each one cycle after acceptance; occupancy stays at 1; stall_cnt=0.
REQ-039 Backpressure: out_ready=0 while entries A and B are pushed -> occupancy=2 and in_ready=0 after the second edge; then out_ready=1 -> A, then B, appear; in_ready returns to 1 one cycle after A leaves; stall_cnt equals the count of stalled valid cycles.
REQ-040 Flush in TWO with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; C never appears at the output.
REQ-041 Reset mid-stream with occupancy=1 and stall_cnt=5 -> all outputs return to the REQ-035 values after one edge; an entry pushed on the next edge appears one cycle later.
REQ-042 Saturation with CNT_W=3: out_valid=1 and out_ready=0 held for 10 cycles -> stall_cnt reads 7 and holds.
REQ-043 Random handshake: randomised in_valid, out_ready and flush over 10k cycles -> the output sequence matches a reference queue model with flush drops, and there is no out-of-order entry.
